// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux path among eight requesters.
// Registered one-hot grant, mux select, busy flag and a bounded hold counter.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       req,
  output logic [7:0]       gnt,
  output logic [2:0]       s,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       s_q, s_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       ptr_q, ptr_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       others;
  logic       regrant;

  // First requester at or after ptr, wrapping 7->0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = req[s_q];
  assign others    = |(req & ~gnt_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    s_d        = s_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    regrant    = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d      = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
        if (win_found) regrant = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (others) begin
            regrant = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q < CNT_W'(MAX_HOLD - 1)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (others) begin
          // ptr already sits at owner+1, so the owner is searched last.
          regrant = 1'b1;
        end else begin
          hold_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (regrant) begin
      state_d    = GRANT;
      gnt_d      = 8'b1 << win_idx;
      s_d        = win_idx;
      busy_d     = 1'b1;
      hold_cnt_d = '0;
      ptr_d      = win_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      s_q        <= '0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      s_q        <= s_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign s        = s_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: default MAX_HOLD=4 instance plus a
// MAX_HOLD=1 instance sharing clock, reset and requests.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       busy;
  logic [3:0] hold_cnt;
  logic [7:0] gnt1;
  logic [2:0] s1;
  logic       busy1;
  logic [3:0] hold_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt), .s(s), .busy(busy), .hold_cnt(hold_cnt)
  );

  mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .gnt(gnt1), .s(s1), .busy(busy1), .hold_cnt(hold_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 8'hFF;
    #2;
    checks++;
    if ({gnt, s, busy, hold_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: gnt=%h s=%0d busy=%0b hold=%0d, expected 00/0/0/0", gnt, s, busy, hold_cnt);
    end
    checks++;
    if ({gnt1, s1, busy1, hold_cnt1} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state_mh1: gnt=%h s=%0d busy=%0b hold=%0d, expected 00/0/0/0", gnt1, s1, busy1, hold_cnt1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if ({gnt, s, busy, hold_cnt} !== {8'h01, 3'd0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%h s=%0d busy=%0b hold=%0d, expected 01/0/1/0", gnt, s, busy, hold_cnt);
    end
  endtask

  // Continues from test_reset with req=FF held; k counts edges since release.
  task automatic test_full_contention();
    logic [7:0] exp_gnt;
    logic [2:0] exp_s;
    logic [3:0] exp_h;
    for (int k = 1; k <= 33; k++) begin
      tick();
      exp_s   = 3'((k / 4) % 8);
      exp_h   = 4'(k % 4);
      exp_gnt = 8'b1 << exp_s;
      checks++;
      if ({gnt, s, busy, hold_cnt} !== {exp_gnt, exp_s, 1'b1, exp_h}) begin
        errors++;
        $display("FAIL contention_k%0d: gnt=%h s=%0d busy=%0b hold=%0d, expected %h/%0d/1/%0d", k, gnt, s, busy, hold_cnt, exp_gnt, exp_s, exp_h);
      end
      exp_s   = 3'(k % 8);
      exp_gnt = 8'b1 << exp_s;
      checks++;
      if ({gnt1, s1, busy1, hold_cnt1} !== {exp_gnt, exp_s, 1'b1, 4'd0}) begin
        errors++;
        $display("FAIL contention_mh1_k%0d: gnt=%h s=%0d busy=%0b hold=%0d, expected %h/%0d/1/0", k, gnt1, s1, busy1, hold_cnt1, exp_gnt, exp_s);
      end
    end
  endtask

  task automatic test_single_drop();
    do_reset();
    req = 8'h20;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({gnt, s, busy, hold_cnt} !== {8'h20, 3'd5, 1'b1, 4'(k)}) begin
        errors++;
        $display("FAIL single_hold_%0d: gnt=%h s=%0d busy=%0b hold=%0d, expected 20/5/1/%0d", k, gnt, s, busy, hold_cnt, k);
      end
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gnt, s, busy, hold_cnt} !== {8'h00, 3'd5, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL single_drop_idle: gnt=%h s=%0d busy=%0b hold=%0d, expected 00/5/0/0", gnt, s, busy, hold_cnt);
    end
    tick();
    checks++;
    if ({gnt, s, busy} !== {8'h00, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL idle_s_stable: gnt=%h s=%0d busy=%0b, expected 00/5/0", gnt, s, busy);
    end
  endtask

  // Lone requester past the hold limit is renewed: hold wraps, grant stays.
  task automatic test_renew();
    do_reset();
    req = 8'h02;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({gnt, s, busy, hold_cnt} !== {8'h02, 3'd1, 1'b1, 4'(k % 4)}) begin
        errors++;
        $display("FAIL renew_%0d: gnt=%h s=%0d busy=%0b hold=%0d, expected 02/1/1/%0d", k, gnt, s, busy, hold_cnt, k % 4);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h40;
    tick();
    checks++;
    if (gnt !== 8'h40) begin
      errors++;
      $display("FAIL wrap_setup: gnt=%h, expected 40", gnt);
    end
    req = 8'h81;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({gnt, s, hold_cnt} !== {8'h80, 3'd7, 4'(k)}) begin
        errors++;
        $display("FAIL wrap_own7_%0d: gnt=%h s=%0d hold=%0d, expected 80/7/%0d", k, gnt, s, hold_cnt, k);
      end
    end
    tick();
    checks++;
    if ({gnt, s, busy, hold_cnt} !== {8'h01, 3'd0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL wrap_to0: gnt=%h s=%0d busy=%0b hold=%0d, expected 01/0/1/0", gnt, s, busy, hold_cnt);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h44;
    tick();
    checks++;
    if ({gnt, s, hold_cnt} !== {8'h04, 3'd2, 4'd1}) begin
      errors++;
      $display("FAIL early_owner2: gnt=%h s=%0d hold=%0d, expected 04/2/1", gnt, s, hold_cnt);
    end
    req = 8'h40;
    tick();
    checks++;
    if ({gnt, s, busy, hold_cnt} !== {8'h40, 3'd6, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL early_handover: gnt=%h s=%0d busy=%0b hold=%0d, expected 40/6/1/0", gnt, s, busy, hold_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h08;
    tick();
    checks++;
    if ({gnt, s, busy} !== {8'h08, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL async_setup: gnt=%h s=%0d busy=%0b, expected 08/3/1", gnt, s, busy);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, s, busy, hold_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_now: gnt=%h s=%0d busy=%0b hold=%0d, expected 00/0/0/0", gnt, s, busy, hold_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if ({gnt, s, busy, hold_cnt} !== {8'h08, 3'd3, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL async_regrant: gnt=%h s=%0d busy=%0b hold=%0d, expected 08/3/1/0", gnt, s, busy, hold_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_contention();
    test_single_drop();
    test_renew();
    test_wrap();
    test_early_release();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 single-bit mux path among eight requesters. It accepts per-requester request lines and issues a one-hot grant. It drives the mux select s[2:0] so the granted requester's input reaches y. A hold counter bounds each grant, so no requester can starve the others.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while others are pending; legal range 1..15.
CNT_W, 4, width of the hold counter; must hold MAX_HOLD-1.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req  input  8  request lines; bit i = requester i wants the mux
gnt  output  8  one-hot grant, registered; bit i = requester i owns the mux
s  output  3  mux select (s2,s1,s0), registered; equals index of granted requester
busy  output  1  registered; 1 whenever any gnt bit is 1
hold_cnt  output  CNT_W  cycles the current owner has held the grant, minus 1; debug/verification visibility

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n. Everything else is synchronous to clk rising edge.
- Reset (reset_n=0, asserted at any time, mid-grant included) takes effect immediately, without waiting for a clock edge:
  - gnt=8'h00, s=3'b000, busy=0, hold_cnt=0.
  - Priority pointer ptr=0; state=IDLE.
  - First arbitration happens on the first rising edge after reset_n returns to 1.
- Priority: search starts at ptr and proceeds ptr, ptr+1, ..., wrapping 7->0. The first requester found with req=1 wins.
- Pointer update: on every new grant, ptr <= winner+1 mod 8. Example: winner 7 gives ptr=0.
- States:
  - IDLE: gnt=0, busy=0. s holds its last granted value so the mux output stays stable.
  - GRANT: exactly one gnt bit set, busy=1.
- IDLE:
  - If any req bit is 1 at a rising edge, go to GRANT.
  - gnt/s/busy reflect the winner after that edge, i.e. 1-cycle latency from req to gnt.
  - hold_cnt <= 0.
- GRANT, evaluated each edge. Owner = index s; others = any req bit other than the owner's.
  - a) req[owner]=0 and others=0 -> go to IDLE; gnt=0, busy=0, s unchanged.
  - b) req[owner]=0 and others=1 -> re-arbitrate in the same cycle; the new winner is granted at that edge, with no idle gap.
  - c) req[owner]=1 and hold_cnt<MAX_HOLD-1 -> keep grant; hold_cnt++.
  - d) req[owner]=1, hold_cnt=MAX_HOLD-1, others=1 -> rotate: grant the next winner from ptr (the owner is excluded because ptr=owner+1); hold_cnt <= 0.
  - e) req[owner]=1, hold_cnt=MAX_HOLD-1, others=0 -> keep grant; hold_cnt <= 0. The owner is renewed and ptr is unchanged.
- Grant handover: never a cycle with two gnt bits set. Handover occurs in a single edge: the old owner's bit falls and the new owner's bit rises at the same edge.
- Invariants:
  - gnt is one-hot or zero.
  - s matches the gnt index whenever busy=1.
  - busy equals |gnt.
- MAX_HOLD=1: every grant lasts exactly one cycle when others are pending, which gives pure per-cycle rotation.
- Requests that change between edges have no effect; only the value sampled at the rising edge matters.

Test Plan:
- Reset: hold reset_n=0 with req=8'hFF, then release -> gnt=0, s=0, busy=0 while in reset. At the first edge after release, gnt=8'h01, s=0, busy=1.
- Single requester, drop: req=8'h20 for 3 cycles, then 0 -> gnt=8'h20, s=5 for 3 cycles; next edge gnt=0, busy=0, s stays 5.
- Full contention, MAX_HOLD=4: req=8'hFF steady from reset -> owner sequence 0,1,2,...,7,0. Each owner holds 4 cycles, with hold_cnt 0,1,2,3 then rotating.
- Wrap-around: ptr=7, req=8'h81 -> requester 7 granted first, then ptr=0, so requester 0 is next. The sequence is not 0 then 7.
- Early release handover: owner 2 drops its req at an edge while req[6]=1 -> at that same edge gnt goes 8'h04 to 8'h40 with no idle cycle, and s goes 2 to 6.
- Async reset mid-grant: assert reset_n=0 between clock edges while gnt=8'h08 -> gnt=0, s=0, busy=0 immediately, before the next edge. After release with req=8'h08, gnt=8'h08 one edge later.
